// File: rtl/eth_rx_framer.sv
// -----------------------------------------------------------------------------
// eth_rx_framer
// RMII receive front-end. Samples crs_dv/rxd once per 50 MHz reference clock.
// It hunts for the preamble (01 dibits) and the SFD (11), then forwards the
// frame body (MAC header through FCS) as a dibit stream. CRC32 is checked on
// the fly, and short, long, misaligned or corrupted frames are flagged.
//
// Ports:
//   clk     in   RMII reference clock, one dibit per cycle
//   rst     in   asynchronous active-high reset
//   crs_dv  in   RMII carrier sense / data valid
//   rxd     in   [1:0] receive dibit, LSB-first bit order
//   outclk  out  body dibit valid strobe
//   out     out  [1:0] body dibit
//   done    out  one-cycle pulse at frame end (good or bad)
//   crc_ok  out  qualifies done: residue, length and alignment all good
//   err     out  one-cycle pulse on abort, or with done when crc_ok=0
//   busy    out  high from SFD acceptance until done
//
// Optional feature macro: ETH_RX_STRIP_FCS_EN
//   When defined, body dibits pass through a 16-dibit delay line. Only dibits
//   followed by at least 16 more are forwarded, so the FCS is not emitted
//   (latency 17). Frame checks and done timing do not change.
// -----------------------------------------------------------------------------
module eth_rx_framer #(
    parameter int MIN_PREAMBLE     = 4,
    parameter int MIN_FRAME_DIBITS = 256,
    parameter int MAX_FRAME_DIBITS = 6088,
    parameter int CNT_WIDTH        = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       crs_dv,
    input  logic [1:0] rxd,
    output logic       outclk,
    output logic [1:0] out,
    output logic       done,
    output logic       crc_ok,
    output logic       err,
    output logic       busy
);

    localparam int PCNT_W = $clog2(MIN_PREAMBLE + 1);
    localparam logic [PCNT_W-1:0]    PRE_MIN  = PCNT_W'(MIN_PREAMBLE);
    localparam logic [PCNT_W-1:0]    PCNT_ONE = PCNT_W'(1);
    localparam logic [CNT_WIDTH-1:0] DMIN     = CNT_WIDTH'(MIN_FRAME_DIBITS);
    localparam logic [CNT_WIDTH-1:0] DMAX     = CNT_WIDTH'(MAX_FRAME_DIBITS);
    localparam logic [CNT_WIDTH-1:0] DCNT_ONE = CNT_WIDTH'(1);
    localparam logic [31:0]          CRC_INIT = 32'hffff_ffff;
    localparam logic [31:0]          CRC_RES  = 32'hdebb_20e3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_BODY     = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    // Advance the reflected CRC32 (poly edb88320) by one LSB-first dibit.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc,
                                                input logic [1:0]  d);
        logic [31:0] c;
        c = crc ^ {30'd0, d};
        for (int i = 0; i < 2; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hedb8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t               state_r, state_s;
    logic [PCNT_W-1:0]    pcnt_r, pcnt_s;
    logic [CNT_WIDTH-1:0] dcnt_r, dcnt_s;
    logic [31:0]          crc_r, crc_s;
    logic                 busy_s, done_s, crc_ok_s, err_s;
    logic                 push_s;      // a body dibit is accepted this cycle
    logic                 good_s;      // frame passes every end-of-frame check
    logic                 fwd_valid_s;
    logic [1:0]           fwd_data_s;

    assign good_s = (crc_r == CRC_RES) && (dcnt_r[1:0] == 2'b00) && (dcnt_r >= DMIN);

    // Next-state, counter, CRC and pulse decode.
    always_comb begin
        state_s  = state_r;
        pcnt_s   = pcnt_r;
        dcnt_s   = dcnt_r;
        crc_s    = crc_r;
        busy_s   = busy;
        done_s   = 1'b0;
        crc_ok_s = 1'b0;
        err_s    = 1'b0;
        push_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (crs_dv) begin
                    if (rxd == 2'b01) begin
                        state_s = ST_PREAMBLE;
                        pcnt_s  = PCNT_ONE;
                    end else if (rxd == 2'b00) begin
                        state_s = ST_IDLE;
                    end else begin
                        // Carrier without a recognisable preamble: ignore silently.
                        state_s = ST_DROP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!crs_dv) begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (rxd == 2'b01) begin
                    if (pcnt_r < PRE_MIN) begin
                        pcnt_s = pcnt_r + PCNT_ONE;
                    end else begin
                        pcnt_s = pcnt_r;
                    end
                end else if ((rxd == 2'b11) && (pcnt_r >= PRE_MIN)) begin
                    state_s = ST_BODY;
                    crc_s   = CRC_INIT;
                    dcnt_s  = '0;
                    busy_s  = 1'b1;
                end else begin
                    err_s   = 1'b1;
                    state_s = ST_DROP;
                end
            end
            ST_BODY: begin
                if (crs_dv) begin
                    if (dcnt_r == DMAX) begin
                        // Already at the legal maximum, yet more data arrives.
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                        busy_s  = 1'b0;
                        state_s = ST_DROP;
                    end else begin
                        push_s = 1'b1;
                        dcnt_s = dcnt_r + DCNT_ONE;
                        crc_s  = crc32_dibit(crc_r, rxd);
                    end
                end else begin
                    done_s   = 1'b1;
                    crc_ok_s = good_s;
                    err_s    = !good_s;
                    busy_s   = 1'b0;
                    state_s  = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!crs_dv) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

`ifdef ETH_RX_STRIP_FCS_EN
    logic [31:0] dly_r;    // 16 dibits, oldest in [31:30]
    logic [4:0]  fill_r;
    logic        flush_s;

    // Any done or error pulse ends the frame, so the delay line empties.
    assign flush_s = done_s || err_s;

    // Delay line that holds back the trailing 16 dibits (the FCS).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_r  <= 32'd0;
            fill_r <= 5'd0;
        end else if (flush_s) begin
            dly_r  <= 32'd0;
            fill_r <= 5'd0;
        end else if (push_s) begin
            dly_r <= {dly_r[29:0], rxd};
            if (fill_r != 5'd16) begin
                fill_r <= fill_r + 5'd1;
            end
        end
    end

    assign fwd_valid_s = push_s && (fill_r == 5'd16);
    assign fwd_data_s  = dly_r[31:30];
`else
    assign fwd_valid_s = push_s;
    assign fwd_data_s  = rxd;
`endif

    // State, counter and CRC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pcnt_r  <= '0;
            dcnt_r  <= '0;
            crc_r   <= CRC_INIT;
        end else begin
            state_r <= state_s;
            pcnt_r  <= pcnt_s;
            dcnt_r  <= dcnt_s;
            crc_r   <= crc_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outclk <= 1'b0;
            out    <= 2'b00;
            done   <= 1'b0;
            crc_ok <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            outclk <= fwd_valid_s;
            out    <= fwd_valid_s ? fwd_data_s : 2'b00;
            done   <= done_s;
            crc_ok <= crc_ok_s;
            err    <= err_s;
            busy   <= busy_s;
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Self-checking bench for eth_rx_framer: table of frame vectors plus
// hand-written sequences (max-length abort, mid-frame reset, drops, back-to-back).
module tb_eth_rx_framer;

`ifdef ETH_RX_STRIP_FCS_EN
    localparam int DLY = 16;
`else
    localparam int DLY = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       crs_dv;
    logic [1:0] rxd;
    logic       outclk;
    logic [1:0] out;
    logic       done;
    logic       crc_ok;
    logic       err;
    logic       busy;

    always #10 clk = ~clk;

    eth_rx_framer dut (
        .clk    (clk),
        .rst    (rst),
        .crs_dv (crs_dv),
        .rxd    (rxd),
        .outclk (outclk),
        .out    (out),
        .done   (done),
        .crc_ok (crc_ok),
        .err    (err),
        .busy   (busy)
    );

    typedef struct {
        string name;
        int    pre;       // number of 01 preamble dibits
        int    nb;        // payload bytes (FCS added on top)
        int    flip;      // byte index whose bit 0 is flipped after FCS, -1 none
        int    trim;      // dibits removed from the end of the body
        int    exp_oc;    // body dibits expected forwarded without FCS strip
        int    exp_done;
        int    exp_ok;
        int    exp_err;
    } vec_t;

    localparam int NV = 10;
    vec_t tv [NV];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int oc_cnt, done_cnt, ok_cnt, err_cnt, orphan_cnt, busy_cnt;
    int first_oc_cyc, last_oc_cyc, done_cyc;
    int first_body_cyc, end_cyc, ndib;
    logic [1:0] rx_q[$];
    logic [1:0] sent_q[$];
    logic [7:0] frm [0:1535];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int eff(input int n);
        return (n > DLY) ? (n - DLY) : 0;
    endfunction

    // Bytewise reflected CRC32 of frm[0..n-1], final-inverted (the FCS value).
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hffff_ffff;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hedb8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic monitor();
        if (outclk) begin
            oc_cnt++;
            if (first_oc_cyc < 0) first_oc_cyc = cyc;
            last_oc_cyc = cyc;
            rx_q.push_back(out);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (crc_ok) ok_cnt++;
        end
        if (crc_ok && !done) orphan_cnt++;
        if (err) err_cnt++;
        if (busy) busy_cnt++;
    endtask

    // One clock: sample outputs of the last edge, then drive the next inputs.
    task automatic step(input logic c, input logic [1:0] d);
        @(negedge clk);
        cyc++;
        monitor();
        crs_dv = c;
        rxd    = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00);
    endtask

    task automatic clr();
        oc_cnt = 0; done_cnt = 0; ok_cnt = 0; err_cnt = 0; orphan_cnt = 0; busy_cnt = 0;
        first_oc_cyc = -1; last_oc_cyc = -1; done_cyc = -1;
        rx_q.delete();
    endtask

    task automatic send_body(input int n);
        for (int k = 0; k < n; k++) begin
            logic [1:0] d;
            d = 2'(frm[k / 4] >> (2 * (k % 4)));
            sent_q.push_back(d);
            step(1'b1, d);
            if (k == 0) first_body_cyc = cyc;
        end
    endtask

    task automatic run_frame(input int pre, input int nb, input int flip, input int trim);
        logic [31:0] f;
        for (int i = 0; i < nb; i++) frm[i] = 8'(i);
        f = fcs_of(nb);
        frm[nb]     = f[7:0];
        frm[nb + 1] = f[15:8];
        frm[nb + 2] = f[23:16];
        frm[nb + 3] = f[31:24];
        if (flip >= 0) frm[flip] = frm[flip] ^ 8'h01;
        ndib = (nb + 4) * 4 - trim;
        sent_q.delete();
        for (int i = 0; i < pre; i++) step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        send_body(ndib);
        step(1'b0, 2'b00);
        end_cyc = cyc;
    endtask

    task automatic chk_data(input string name, input int n);
        int mm;
        mm = 0;
        for (int k = 0; k < n; k++) begin
            if (k >= rx_q.size() || k >= sent_q.size()) mm++;
            else if (rx_q[k] != sent_q[k]) mm++;
        end
        chk(name, mm, 0);
    endtask

    initial begin
        tv[0] = '{"good64",     28,   60, -1, 0,  256, 1, 1, 0};
        tv[1] = '{"crc_bad",    28,   60, 10, 0,  256, 1, 0, 1};
        tv[2] = '{"short_pre",   2,   60, -1, 0,    0, 0, 0, 1};
        tv[3] = '{"good_after", 28,   60, -1, 0,  256, 1, 1, 0};
        tv[4] = '{"odd255",     28,   60, -1, 1,  255, 1, 0, 1};
        tv[5] = '{"runt96",      8,   20, -1, 0,   96, 1, 0, 1};
        tv[6] = '{"pre_min4",    4,   60, -1, 0,  256, 1, 1, 0};
        tv[7] = '{"pre_3",       3,   60, -1, 0,    0, 0, 0, 1};
        tv[8] = '{"max1522",     8, 1518, -1, 0, 6088, 1, 1, 0};
        tv[9] = '{"mid416",      8,  100, -1, 0,  416, 1, 1, 0};

        rst = 1'b1; crs_dv = 1'b0; rxd = 2'b00;
        clr();
        idle(3);
        chk("reset_outputs", int'({outclk, out, done, crc_ok, err, busy}), 0);
        rst = 1'b0;
        idle(2);

        for (int v = 0; v < NV; v++) begin
            int exp;
            clr();
            run_frame(tv[v].pre, tv[v].nb, tv[v].flip, tv[v].trim);
            idle(3);
            exp = eff(tv[v].exp_oc);
            chk({tv[v].name, ".outclk"}, oc_cnt, exp);
            chk({tv[v].name, ".done"},   done_cnt, tv[v].exp_done);
            chk({tv[v].name, ".crc_ok"}, ok_cnt, tv[v].exp_ok);
            chk({tv[v].name, ".err"},    err_cnt, tv[v].exp_err);
            chk({tv[v].name, ".orphan_ok"}, orphan_cnt, 0);
            chk({tv[v].name, ".busy"},   busy_cnt, tv[v].exp_done ? ndib + 1 : 0);
            chk_data({tv[v].name, ".data"}, exp);
            if (exp > 0) chk({tv[v].name, ".latency"}, first_oc_cyc, first_body_cyc + 1 + DLY);
            if (tv[v].exp_done != 0) chk({tv[v].name, ".done_time"}, done_cyc, end_cyc + 1);
        end

        // Oversized frame: 6100 body dibits, abort once the maximum is exceeded.
        clr();
        sent_q.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        for (int k = 0; k < 6100; k++) begin
            logic [1:0] d;
            d = 2'($urandom_range(0, 3));
            sent_q.push_back(d);
            step(1'b1, d);
            if (k == 0) first_body_cyc = cyc;
        end
        step(1'b0, 2'b00);
        idle(3);
        chk("long.outclk", oc_cnt, eff(6088));
        chk("long.done", done_cnt, 1);
        chk("long.crc_ok", ok_cnt, 0);
        chk("long.err", err_cnt, 1);
        chk("long.done_time", done_cyc, first_body_cyc + 6089);
        chk("long.silent_after", int'(last_oc_cyc < done_cyc), 1);
        chk("long.busy", busy_cnt, 6089);
        chk_data("long.data", eff(6088));

        // Reset in the middle of a body.
        clr();
        sent_q.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        for (int i = 0; i < 60; i++) frm[i] = 8'(i);
        send_body(100);
        @(negedge clk);
        cyc++;
        monitor();
        rst = 1'b1;
        crs_dv = 1'b1;
        rxd = 2'b10;
        step(1'b0, 2'b00);
        chk("rst_mid.outputs", int'({outclk, out, done, crc_ok, err, busy}), 0);
        rst = 1'b0;
        idle(3);
        chk("rst_mid.outclk", oc_cnt, eff(100));
        chk("rst_mid.no_done", done_cnt, 0);
        chk("rst_mid.no_err", err_cnt, 0);
        clr();
        run_frame(8, 60, -1, 0);
        idle(3);
        chk("rst_mid.next_ok", ok_cnt, 1);
        chk("rst_mid.next_err", err_cnt, 0);

        // Bad first dibit in IDLE: silently dropped, no err.
        clr();
        step(1'b1, 2'b10);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        for (int i = 0; i < 20; i++) step(1'b1, 2'b01);
        step(1'b0, 2'b00);
        idle(3);
        chk("idle_drop.err", err_cnt, 0);
        chk("idle_drop.outclk", oc_cnt, 0);
        chk("idle_drop.done", done_cnt, 0);

        // Carrier lost during the preamble.
        clr();
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01);
        step(1'b0, 2'b00);
        idle(2);
        chk("pre_lost.err", err_cnt, 1);
        chk("pre_lost.done", done_cnt, 0);
        chk("pre_lost.busy", busy_cnt, 0);

        // Back-to-back frames separated by a single crs_dv=0 cycle.
        clr();
        run_frame(8, 60, -1, 0);
        run_frame(8, 60, -1, 0);
        idle(3);
        chk("b2b.done", done_cnt, 2);
        chk("b2b.crc_ok", ok_cnt, 2);
        chk("b2b.err", err_cnt, 0);
        chk("b2b.outclk", oc_cnt, 2 * eff(256));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
